// File: rtl/vga_timing_counter.sv
// vga_timing_counter: pixel-rate enable plus horizontal/vertical scan
// counters for an 800x525 VGA frame with a 640x480 visible window.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   run       in   count enable; low freezes divider and counters
//   pix_en    out  one-clk strobe at the pixel rate
//   h_count   out  horizontal slot 0..H_TOTAL-1 (hsync comparator input)
//   v_count   out  vertical line 0..V_TOTAL-1 (vsync comparator input)
//   active    out  (h_count, v_count) lies in the visible window
//   pix_x     out  visible column, 0 outside the window
//   pix_y     out  visible row, 0 outside the window
//   line_end  out  strobe on the last pixel slot of each line
//   frame_end out  strobe on the last pixel slot of each frame
module vga_timing_counter #(
    parameter int CLK_DIV  = 2,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_SYNC   = 96,
    parameter int V_SYNC   = 2,
    parameter int H_BACK   = 48,
    parameter int V_BACK   = 33,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       pix_en,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       active,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       line_end,
    output logic       frame_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HA0   = H_SYNC + H_BACK;
    localparam int HA1   = HA0 + H_ACTIVE;
    localparam int VA0   = V_SYNC + V_BACK;
    localparam int VA1   = VA0 + V_ACTIVE;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Window bounds are compared at 11 bits so an upper bound of
    // exactly 1024 does not alias to zero.
    localparam logic [10:0] H_LO = 11'(HA0);
    localparam logic [10:0] H_HI = 11'(HA1);
    localparam logic [10:0] V_LO = 11'(VA0);
    localparam logic [10:0] V_HI = 11'(VA1);

    localparam logic [9:0] H_OFF = 10'(HA0);
    localparam logic [8:0] V_OFF = 9'(VA0);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_counter: CLK_DIV must be 1..16");
    end
    if (H_TOTAL < 1 || H_TOTAL > 1024) begin : g_bad_htot
        $error("vga_timing_counter: H_TOTAL must be 1..1024");
    end
    if (V_TOTAL < 1 || V_TOTAL > 1024) begin : g_bad_vtot
        $error("vga_timing_counter: V_TOTAL must be 1..1024");
    end
    if (HA1 > H_TOTAL) begin : g_bad_hwin
        $error("vga_timing_counter: horizontal window exceeds H_TOTAL");
    end
    if (VA1 > V_TOTAL) begin : g_bad_vwin
        $error("vga_timing_counter: vertical window exceeds V_TOTAL");
    end
    if (V_ACTIVE > 512) begin : g_bad_vact
        $error("vga_timing_counter: V_ACTIVE must fit in 9 bits");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;

    logic div_wrap;
    logic h_wrap;
    logic v_wrap;
    logic h_in;
    logic v_in;

    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        h_wrap   = (h_q == H_LAST);
        v_wrap   = (v_q == V_LAST);

        // Reset masks the strobe so no downstream logic sees a pixel
        // slot while the counters are being cleared.
        pix_en    = run & div_wrap & ~reset;
        line_end  = pix_en & h_wrap;
        frame_end = line_end & v_wrap;

        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;

        if (run) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
        end

        // The vertical step rides on the horizontal wrap, so both
        // counters roll over on the same edge at end of frame.
        if (pix_en) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= 10'd0;
            v_q   <= 10'd0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        h_in   = ({1'b0, h_q} >= H_LO) && ({1'b0, h_q} < H_HI);
        v_in   = ({1'b0, v_q} >= V_LO) && ({1'b0, v_q} < V_HI);
        active = h_in & v_in;

        pix_x = 10'd0;
        pix_y = 9'd0;
        // The row offset is taken modulo 512; the visible row always
        // fits, so the dropped top bit never carries information.
        if (active) begin
            pix_x = h_q - H_OFF;
            pix_y = v_q[8:0] - V_OFF;
        end
    end

    assign h_count = h_q;
    assign v_count = v_q;

endmodule

// File: tb/tb_vga_timing_counter.sv
// tb_vga_timing_counter: scoreboard bench for vga_timing_counter.
// Three builds: default CLK_DIV=2, CLK_DIV=1, and a tiny frame.
module tb_vga_timing_counter;

    localparam int NI = 3;
    localparam int CD [NI] = '{2, 1, 3};
    localparam int HT [NI] = '{800, 800, 20};
    localparam int VT [NI] = '{525, 525, 10};
    localparam int HS [NI] = '{96, 96, 2};
    localparam int HB [NI] = '{48, 48, 3};
    localparam int HA [NI] = '{640, 640, 10};
    localparam int VS [NI] = '{2, 2, 1};
    localparam int VB [NI] = '{33, 33, 2};
    localparam int VA [NI] = '{480, 480, 5};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic steady = 1'b0;

    logic       pe [NI];
    logic [9:0] hc [NI];
    logic [9:0] vc [NI];
    logic       ac [NI];
    logic [9:0] px [NI];
    logic [8:0] py [NI];
    logic       le [NI];
    logic       fe [NI];

    always #5 clk = ~clk;

    vga_timing_counter u_d2 (
        .clk(clk), .reset(reset), .run(run),
        .pix_en(pe[0]), .h_count(hc[0]), .v_count(vc[0]),
        .active(ac[0]), .pix_x(px[0]), .pix_y(py[0]),
        .line_end(le[0]), .frame_end(fe[0])
    );

    vga_timing_counter #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .run(run),
        .pix_en(pe[1]), .h_count(hc[1]), .v_count(vc[1]),
        .active(ac[1]), .pix_x(px[1]), .pix_y(py[1]),
        .line_end(le[1]), .frame_end(fe[1])
    );

    vga_timing_counter #(
        .CLK_DIV(3), .H_TOTAL(20), .V_TOTAL(10),
        .H_SYNC(2), .H_BACK(3), .H_ACTIVE(10),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(5)
    ) u_small (
        .clk(clk), .reset(reset), .run(run),
        .pix_en(pe[2]), .h_count(hc[2]), .v_count(vc[2]),
        .active(ac[2]), .pix_x(px[2]), .pix_y(py[2]),
        .line_end(le[2]), .frame_end(fe[2])
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    typedef struct {
        int          k;
        logic [42:0] v;
    } exp_t;

    exp_t sb [$];
    exp_t e;

    int div_m [NI];
    int idx_m [NI];

    // Reference: position is a linear pixel index within the frame,
    // from which h/v are derived by division.
    function automatic logic [42:0] model_out(int k, logic r, logic ru);
        int h = idx_m[k] % HT[k];
        int v = idx_m[k] / HT[k];
        int h0 = HS[k] + HB[k];
        int v0 = VS[k] + VB[k];
        logic p = !r && ru && (div_m[k] == CD[k] - 1);
        logic a = (h >= h0) && (h < h0 + HA[k]) &&
                  (v >= v0) && (v < v0 + VA[k]);
        logic l = p && (h == HT[k] - 1);
        logic f = l && (v == VT[k] - 1);
        logic [9:0] x = a ? 10'(h - h0) : 10'd0;
        logic [8:0] y = a ? 9'(v - v0) : 9'd0;
        return {p, l, f, a, 10'(h), 10'(v), x, y};
    endfunction

    function automatic logic [42:0] observed(int k);
        return {pe[k], le[k], fe[k], ac[k], hc[k], vc[k], px[k], py[k]};
    endfunction

    task automatic cyc(input logic r, input logic ru);
        #1;
        reset = r;
        run = ru;
        for (int k = 0; k < NI; k++) begin
            logic p = !r && ru && (div_m[k] == CD[k] - 1);
            sb.push_back('{k, model_out(k, r, ru)});
            if (r) begin
                div_m[k] = 0;
                idx_m[k] = 0;
            end else if (ru) begin
                if (p) idx_m[k] = (idx_m[k] + 1) % (HT[k] * VT[k]);
                div_m[k] = (div_m[k] == CD[k] - 1) ? 0 : div_m[k] + 1;
            end
        end
        @(posedge clk);
    endtask

    int cyc_n = 0;
    int hs_run = 0;
    logic hs_clean = 1'b0;
    int fe_last = -1;

    always @(negedge clk) begin
        cyc_n++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("u%0d outputs cyc %0d", e.k, cyc_n),
                  64'(observed(e.k)), 64'(e.v));
        end
        if (!steady) begin
            hs_clean = 1'b0;
            fe_last = -1;
        end else begin
            if (hc[1] == 10'd0) begin
                hs_run = 1;
                hs_clean = 1'b1;
            end else if (hc[1] < 10'd96) begin
                if (hs_clean) hs_run++;
            end else if (hs_clean) begin
                check("hsync width", 64'(hs_run), 64'(96));
                hs_clean = 1'b0;
            end
            if (fe[2]) begin
                if (fe_last >= 0)
                    check("frame period", 64'(cyc_n - fe_last),
                          64'(HT[2] * VT[2] * CD[2]));
                fe_last = cyc_n;
            end
        end
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            div_m[k] = 0;
            idx_m[k] = 0;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 2000 && idx_m[0] != 500; i++)
            cyc(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 2000 && idx_m[0] != 810; i++)
            cyc(1'b0, 1'b1);
        steady = 1'b1;
        for (int i = 0; i < 30000; i++) cyc(1'b0, 1'b1);
        steady = 1'b0;
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule

// File: doc/vga_timing_counter.md
Name: vga_timing_counter

Overview:
- Generates the horizontal and vertical scan counters that drive the downstream HS/VS sync comparators (hsync = h_count < 96, vsync = v_count < 2).
- Derives a pixel-rate enable from the system clock and walks the 800x525 VGA frame.
- Flags the 640x480 active region, producing zero-based pixel coordinates and line/frame strobes for the pixel generator.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal range 1..16.
- H_TOTAL, 800, pixel slots per line.
- V_TOTAL, 525, lines per frame.
- H_SYNC, 96, hsync width in pixels (matches downstream comparator constant).
- V_SYNC, 2, vsync width in lines (matches downstream comparator constant).
- H_BACK, 48, horizontal back porch.
- V_BACK, 33, vertical back porch.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  count enable; low freezes all state.
- pix_en  output  1  one-clk strobe at pixel rate.
- h_count  output  10  horizontal position 0..H_TOTAL-1; feeds hsync comparator input a.
- v_count  output  10  vertical position 0..V_TOTAL-1; feeds vsync comparator input a.
- active  output  1  current (h_count, v_count) is inside the visible region.
- pix_x  output  10  visible column 0..H_ACTIVE-1; 0 when not active.
- pix_y  output  9  visible row 0..V_ACTIVE-1; 0 when not active.
- line_end  output  1  strobe on last pixel slot of a line.
- frame_end  output  1  strobe on last pixel slot of a frame.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on the rising edge of clk.
- Reset values: div_cnt=0, h_count=0, v_count=0, and all outputs 0.
- Reset asserted mid-frame returns every register to its reset value on the next edge; there is no partial state.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while run=1, then wraps to 0.
  - pix_en = run & (div_cnt == CLK_DIV-1), forced 0 during reset.
  - With CLK_DIV=1, pix_en = run every cycle.
- Horizontal counter:
  - On an edge with pix_en=1, h_count increments.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - v_count increments only on the same edge as the h_count wrap.
  - At V_TOTAL-1 it wraps to 0, so the two wraps are simultaneous at end of frame.
- No pix_en means no counter change.
- run=0:
  - div_cnt, h_count and v_count hold their values; pix_en, line_end and frame_end are 0.
  - Resuming continues from the held div_cnt.
- Region boundaries (defaults):
  - HA0 = H_SYNC+H_BACK = 144.
  - VA0 = V_SYNC+V_BACK = 35.
- active = (HA0 <= h_count < HA0+H_ACTIVE) & (VA0 <= v_count < VA0+V_ACTIVE), i.e. h 144..783 and v 35..514.
- Coordinates:
  - pix_x = h_count-HA0 and pix_y = v_count-VA0 when active, else 0.
  - pix_y is truncated to 9 bits, which is sufficient because V_ACTIVE <= 512.
- active, pix_x and pix_y are combinational from the counter registers: zero latency relative to h_count/v_count.
- line_end = pix_en & (h_count == H_TOTAL-1).
- frame_end = line_end & (v_count == V_TOTAL-1).
- Each strobe is high for exactly one clk per line or frame.
- Arithmetic:
  - Counters are 10-bit unsigned.
  - Parameters must satisfy H_TOTAL, V_TOTAL <= 1024 and H_SYNC+H_BACK+H_ACTIVE <= H_TOTAL (likewise vertical); otherwise elaboration-time error.
- Sync outputs are not generated here. The downstream comparators see h_count/v_count directly, so their values must never exceed TOTAL-1.

Test Plan:
- Reset/divider, CLK_DIV=2: hold reset 3 clks, then release with run=1 -> h_count=v_count=0 and outputs 0 during reset; pix_en high on clks 2,4,6... after release; h_count=1 after first pix_en edge.
- Line wrap: run to h_count=799, v_count=0 -> line_end high for exactly 1 clk; next pix_en edge gives h_count=0, v_count=1; frame_end stays 0.
- Frame wrap: h=799, v=524 -> line_end=frame_end=1 for 1 clk; then h=0, v=0; total frame period = 800*525*2 = 840000 clks between frame_end strobes.
- Active window: h=143,v=35 -> active=0; h=144,v=35 -> active=1, pix_x=0, pix_y=0; h=783,v=514 -> pix_x=639, pix_y=479; h=784 -> active=0, pix_x=0; v=515 -> active=0.
- run gating: drop run at h=500 for 7 clks -> counters hold at 500 and pix_en=0 throughout; resume -> next increment after remaining divider count. Separately, assert reset mid-line at h=400, v=200 -> all zero on next edge.
- CLK_DIV=1 build: pix_en constant 1 with run=1; h_count increments every clk; hsync comparator output (h<96) is high for exactly 96 consecutive clks per 800.
